// File: rtl/lsu_ctrl.sv
// Load/store controller between the MEM stage and a word-addressed 4 KB data BRAM.
// Stores take 2 cycles, loads 3, misaligned or illegal accesses 1; one IDLE cycle separates requests.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_dm_select,
  output logic        req_ready,
  output logic        dm_en,
  output logic [3:0]  dm_wea,
  output logic [9:0]  dm_addr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [1:0]  ld_byte_offset,
  output logic [2:0]  ld_dm_select,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        dm_en_q, dm_en_d;
  logic [3:0]  dm_wea_q, dm_wea_d;
  logic [9:0]  dm_addr_q, dm_addr_d;
  logic [31:0] dm_din_q, dm_din_d;
  logic        ld_valid_q, ld_valid_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic [2:0]  ld_sel_q, ld_sel_d;
  logic        misalign_q, misalign_d;
  logic        ready_q, ready_d;
  logic        is_load_q, is_load_d;

  // Address bits above the 4 KB window are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:12];

  function automatic logic access_bad(input logic [2:0] sel, input logic [1:0] off);
    case (sel)
      3'd0, 3'd4: access_bad = 1'b0;
      3'd1, 3'd5: access_bad = off[0];
      3'd2:       access_bad = (off != 2'd0);
      default:    access_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_lanes(input logic [2:0] sel, input logic [1:0] off);
    case (sel[1:0])
      2'd0:    store_lanes = 4'b0001 << off;
      2'd1:    store_lanes = off[1] ? 4'b1100 : 4'b0011;
      default: store_lanes = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] sel, input logic [31:0] wdata);
    case (sel[1:0])
      2'd0:    store_data = {4{wdata[7:0]}};
      2'd1:    store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    dm_en_d    = 1'b0;
    dm_wea_d   = 4'b0000;
    dm_addr_d  = dm_addr_q;
    dm_din_d   = dm_din_q;
    ld_valid_d = 1'b0;
    ld_data_d  = ld_data_q;
    ld_off_d   = ld_off_q;
    ld_sel_d   = ld_sel_q;
    misalign_d = 1'b0;
    ready_d    = 1'b0;
    is_load_d  = is_load_q;
    case (state_q)
      // Request intake: bad accesses skip the BRAM entirely.
      IDLE: begin
        if (req_valid) begin
          if (access_bad(req_dm_select, req_addr[1:0])) begin
            state_d    = DONE;
            ready_d    = 1'b1;
            misalign_d = 1'b1;
            is_load_d  = 1'b0;
          end else begin
            state_d   = ACCESS;
            dm_en_d   = 1'b1;
            dm_addr_d = req_addr[11:2];
            is_load_d = ~req_we;
            if (req_we) begin
              dm_wea_d = store_lanes(req_dm_select, req_addr[1:0]);
              dm_din_d = store_data(req_dm_select, req_wdata);
            end
          end
        end
      end
      // BRAM samples the enable this cycle.
      ACCESS: begin
        if (is_load_q) begin
          state_d = WAIT;
        end else begin
          state_d = DONE;
          ready_d = 1'b1;
        end
      end
      // Read data is valid now; capture it with its alignment info.
      WAIT: begin
        state_d    = DONE;
        ld_data_d  = dm_dout;
        ld_off_d   = req_addr[1:0];
        ld_sel_d   = req_dm_select;
        ld_valid_d = 1'b1;
        ready_d    = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dm_en_q    <= 1'b0;
      dm_wea_q   <= 4'b0000;
      dm_addr_q  <= 10'd0;
      dm_din_q   <= 32'd0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= 32'd0;
      ld_off_q   <= 2'd0;
      ld_sel_q   <= 3'd0;
      misalign_q <= 1'b0;
      ready_q    <= 1'b0;
      is_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dm_en_q    <= dm_en_d;
      dm_wea_q   <= dm_wea_d;
      dm_addr_q  <= dm_addr_d;
      dm_din_q   <= dm_din_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
      ld_off_q   <= ld_off_d;
      ld_sel_q   <= ld_sel_d;
      misalign_q <= misalign_d;
      ready_q    <= ready_d;
      is_load_q  <= is_load_d;
    end
  end

  assign req_ready      = ready_q;
  assign dm_en          = dm_en_q;
  assign dm_wea         = dm_wea_q;
  assign dm_addr        = dm_addr_q;
  assign dm_din         = dm_din_q;
  assign ld_valid       = ld_valid_q;
  assign ld_data        = ld_data_q;
  assign ld_byte_offset = ld_off_q;
  assign ld_dm_select   = ld_sel_q;
  assign misalign       = misalign_q;

endmodule
